// File: rtl/jellyvl_etherneco_pkg.sv
// Shared constants and types for the EtherNeco ring-bus time-sync blocks.
package jellyvl_etherneco_pkg;

  // Packet type of a time-sync command
  localparam logic [7:0] TIMSYNC = 8'h10;

  // Bit indices inside the flags byte
  localparam int unsigned FLAG_OVERRIDE = 0;
  localparam int unsigned FLAG_CORRECT  = 1;

  // Payload layout (byte positions)
  localparam int unsigned FLAGS_POS  = 0;
  localparam int unsigned TIME_POS   = 1;
  localparam int unsigned TIME_BYTES = 8;
  localparam int unsigned SLOT_BASE  = 9;
  localparam int unsigned SLOT_SIZE  = 4;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    APPLY
  } responder_state_t;

endpackage

// File: rtl/jellyvl_etherneco_synctimer_timer.sv
// Free-running local timer with absolute load and low-pass corrected adjust.
// o_offset is the saturated signed difference (i_target - current time).
module jellyvl_etherneco_synctimer_timer #(
  parameter int unsigned TIMER_WIDTH     = 64,
  parameter int unsigned NUMERATOR       = 8,
  parameter int unsigned OFFSET_WIDTH    = 24,
  parameter int unsigned OFFSET_LPF_GAIN = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_override,
  input  logic                    i_correct,
  input  logic [TIMER_WIDTH-1:0]  i_target,
  output logic [TIMER_WIDTH-1:0]  o_current_time,
  output logic [OFFSET_WIDTH-1:0] o_offset
);

  localparam logic [TIMER_WIDTH-1:0] STEP = TIMER_WIDTH'(NUMERATOR);
  localparam logic signed [TIMER_WIDTH-1:0] OFS_MAX =
    {{(TIMER_WIDTH-OFFSET_WIDTH+1){1'b0}}, {(OFFSET_WIDTH-1){1'b1}}};
  localparam logic signed [TIMER_WIDTH-1:0] OFS_MIN =
    {{(TIMER_WIDTH-OFFSET_WIDTH+1){1'b1}}, {(OFFSET_WIDTH-1){1'b0}}};

  logic        [TIMER_WIDTH-1:0]  r_time;
  logic signed [TIMER_WIDTH-1:0]  w_diff;
  logic signed [OFFSET_WIDTH-1:0] w_offset;
  logic signed [OFFSET_WIDTH-1:0] w_shift;
  logic        [TIMER_WIDTH-1:0]  w_corr;

  // Saturate the modular difference to the offset width, then scale by the LPF gain
  always_comb begin
    w_diff = signed'(i_target - r_time);
    if (w_diff > OFS_MAX) begin
      w_offset = OFS_MAX[OFFSET_WIDTH-1:0];
    end else if (w_diff < OFS_MIN) begin
      w_offset = OFS_MIN[OFFSET_WIDTH-1:0];
    end else begin
      w_offset = w_diff[OFFSET_WIDTH-1:0];
    end
    w_shift = w_offset >>> OFFSET_LPF_GAIN;
    w_corr  = {{(TIMER_WIDTH-OFFSET_WIDTH){w_shift[OFFSET_WIDTH-1]}}, w_shift};
  end

  // Timer advance: a load or correction replaces the plain increment for that cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_time <= '0;
    end else if (i_override) begin
      r_time <= i_target + STEP;
    end else if (i_correct) begin
      r_time <= r_time + STEP + w_corr;
    end else begin
      r_time <= r_time + STEP;
    end
  end

  assign o_current_time = r_time;
  assign o_offset       = w_offset;

endmodule

// File: rtl/jellyvl_etherneco_synctimer_responder.sv
// Slave-node time-sync responder: parses sync commands, maintains the local
// timer and stamps its own receive time into its payload slot.
module jellyvl_etherneco_synctimer_responder
  import jellyvl_etherneco_pkg::*;
#(
  parameter int unsigned TIMER_WIDTH     = 64,
  parameter int unsigned NUMERATOR       = 8,
  parameter int unsigned OFFSET_WIDTH    = 24,
  parameter int unsigned OFFSET_LPF_GAIN = 4,
  parameter int unsigned RX_LATENCY      = 16,
  parameter logic [7:0]  PACKET_TYPE     = TIMSYNC
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              node_id,
  output logic [TIMER_WIDTH-1:0]  current_time,
  input  logic                    rx_start,
  input  logic                    rx_end,
  input  logic                    rx_error,
  input  logic [7:0]              rx_type,
  input  logic [7:0]              rx_node,
  input  logic                    payload_first,
  input  logic                    payload_last,
  input  logic [15:0]             payload_pos,
  input  logic [7:0]              payload_data,
  input  logic                    payload_valid,
  output logic [7:0]              replace_data,
  output logic                    replace_valid,
  output logic                    sync_valid,
  output logic [OFFSET_WIDTH-1:0] sync_offset
);

  localparam logic [3:0] MIN_BYTES = 4'(TIME_POS + TIME_BYTES);

  responder_state_t        r_state;
  responder_state_t        w_next;
  logic [TIMER_WIDTH-1:0]  r_rx_time;
  logic [1:0]              r_flags;
  logic [63:0]             r_master_time;
  logic [3:0]              r_count;
  logic [OFFSET_WIDTH-1:0] r_sync_offset;

  logic                    w_start;
  logic                    w_recv_byte;
  logic                    w_override;
  logic                    w_correct;
  logic [TIMER_WIDTH-1:0]  w_time;
  logic [TIMER_WIDTH-1:0]  w_target;
  logic [OFFSET_WIDTH-1:0] w_offset;
  logic [31:0]             w_slot_base;
  logic [31:0]             w_slot_rel;
  logic                    w_in_slot;
  logic                    w_unused;

  // Header fields not needed here; payload framing comes from payload_pos
  assign w_unused = ^{rx_node, payload_first, payload_last};

  assign w_start     = rx_start && (rx_type == PACKET_TYPE);
  assign w_recv_byte = (r_state == RECV) && payload_valid && !rx_start;
  assign w_target    = TIMER_WIDTH'(r_master_time) + TIMER_WIDTH'(RX_LATENCY)
                     + (w_time - r_rx_time);

  // Next-state and apply decode; any new header restarts or aborts the capture
  always_comb begin
    w_next     = r_state;
    w_override = 1'b0;
    w_correct  = 1'b0;
    unique case (r_state)
      IDLE: w_next = IDLE;
      RECV: begin
        if (rx_error) begin
          w_next = IDLE;
        end else if (rx_end) begin
          w_next = (r_count >= MIN_BYTES) ? APPLY : IDLE;
        end
      end
      APPLY: begin
        w_next     = IDLE;
        w_override = r_flags[FLAG_OVERRIDE];
        w_correct  = r_flags[FLAG_CORRECT] && !r_flags[FLAG_OVERRIDE];
      end
      default: w_next = IDLE;
    endcase
    if (rx_start) begin
      w_next = w_start ? RECV : IDLE;
    end
    sync_valid = w_override || w_correct;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Capture of receive time, flags and master time; latch the offset on apply
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_time     <= '0;
      r_flags       <= '0;
      r_master_time <= '0;
      r_count       <= '0;
      r_sync_offset <= '0;
    end else begin
      if (w_start) begin
        r_rx_time     <= w_time;
        r_flags       <= '0;
        r_master_time <= '0;
        r_count       <= '0;
      end else if (w_recv_byte) begin
        if (r_count < MIN_BYTES) begin
          r_count <= r_count + 4'd1;
        end
        if (payload_pos == 16'(FLAGS_POS)) begin
          r_flags <= payload_data[1:0];
        end
        for (int unsigned i = 0; i < TIME_BYTES; i++) begin
          if (payload_pos == 16'(TIME_POS + i)) begin
            r_master_time[i*8 +: 8] <= payload_data;
          end
        end
      end
      if (w_override || w_correct) begin
        r_sync_offset <= w_offset;
      end
    end
  end

  // Own-slot substitution of rx_time[31:0], little-endian; node 0 has no slot
  always_comb begin
    w_slot_base   = 32'(SLOT_BASE) + 32'(SLOT_SIZE) * (32'(node_id) - 32'd1);
    w_slot_rel    = 32'(payload_pos) - w_slot_base;
    w_in_slot     = (node_id != 8'd0) && (32'(payload_pos) >= w_slot_base)
                  && (w_slot_rel < 32'(SLOT_SIZE));
    replace_valid = payload_valid && (r_state == RECV) && w_in_slot;
    replace_data  = '0;
    if (replace_valid) begin
      replace_data = r_rx_time[{w_slot_rel[1:0], 3'b000} +: 8];
    end
  end

  jellyvl_etherneco_synctimer_timer #(
    .TIMER_WIDTH     (TIMER_WIDTH),
    .NUMERATOR       (NUMERATOR),
    .OFFSET_WIDTH    (OFFSET_WIDTH),
    .OFFSET_LPF_GAIN (OFFSET_LPF_GAIN)
  ) u_timer (
    .clk            (clk),
    .reset          (reset),
    .i_override     (w_override),
    .i_correct      (w_correct),
    .i_target       (w_target),
    .o_current_time (w_time),
    .o_offset       (w_offset)
  );

  assign current_time = w_time;
  assign sync_offset  = r_sync_offset;

endmodule

// File: doc/jellyvl_etherneco_synctimer_responder.md
Name: jellyvl_etherneco_synctimer_responder

Overview:
- Slave-node counterpart of the ring-bus time-sync master.
- Sits behind a node's downstream packet receiver. It parses time-sync command packets (type 0x10), keeps the node's local timer, and applies override or corrected offsets from the master timestamp.
- Writes the node's own receive timestamp into its payload slot through the receiver's replace path, so the master can measure ring latency.

Parameters:
- TIMER_WIDTH, 64: local timer width (bits).
- NUMERATOR, 8: timer increment per clk.
- OFFSET_WIDTH, 24: signed offset width; the offset saturates to this width.
- OFFSET_LPF_GAIN, 4: correction applied = offset >>> GAIN (arithmetic shift).
- RX_LATENCY, 16: fixed PHY and packet latency added to the master time (timer units).
- PACKET_TYPE, 8'h10: type value accepted as a time-sync command.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- node_id  in  8  this node's ring index (1..255); quasi-static
- current_time  out  TIMER_WIDTH  local timer
- rx_start  in  1  header accepted pulse
- rx_end  in  1  packet completed with good CRC, pulse
- rx_error  in  1  packet aborted or CRC bad, pulse
- rx_type  in  8  packet type, valid from rx_start
- rx_node  in  8  packet node field, valid from rx_start
- payload_first  in  1  first payload byte
- payload_last  in  1  last payload byte
- payload_pos  in  16  payload byte index
- payload_data  in  8  payload byte
- payload_valid  in  1  payload byte strobe
- replace_data  out  8  substitute byte
- replace_valid  out  1  substitute the current byte
- sync_valid  out  1  pulse: timer loaded or corrected
- sync_offset  out  OFFSET_WIDTH  last measured offset (signed)

Behaviour:
- Reset values: current_time=0, sync_valid=0, sync_offset=0, state=IDLE. replace_valid=0 whenever payload_valid=0.
- Timer: current_time += NUMERATOR every cycle, wrapping modulo 2^TIMER_WIDTH. A load or correct replaces that cycle's increment with the adjusted value plus NUMERATOR.
- Payload map, little-endian:
  - pos 0: flags. bit0 = override, bit1 = correct.
  - pos 1..8: master time, 64 bits.
  - pos 9+4*(node_id-1) .. +3: this node's slot.
- FSM states: IDLE, RECV, APPLY.
- IDLE -> RECV on rx_start with rx_type==PACKET_TYPE. Other types are ignored and the FSM stays in IDLE. On entering RECV, capture rx_time = current_time of the rx_start cycle.
- RECV:
  - Latch flags at pos 0 and master-time bytes at pos 1..8 on payload_valid.
  - rx_end -> APPLY.
  - rx_error -> IDLE; nothing applied, sync_valid stays 0.
  - rx_start while in RECV restarts the capture (new rx_time, fields cleared).
- Replace path (combinational, zero delay):
  - replace_valid = payload_valid && state==RECV && pos inside own slot.
  - replace_data = byte (pos - slot_base) of rx_time[31:0].
  - Slot positions beyond payload_last are never written.
  - node_id=0 disables replacement.
- APPLY (1 cycle), then IDLE:
  - target = master_time + RX_LATENCY + (current_time - rx_time), modulo 2^TIMER_WIDTH.
  - override set: current_time <= target + NUMERATOR; sync_offset <= saturated (target - current_time).
  - else correct set: off = sat_OFFSET_WIDTH(target - current_time, signed); current_time <= current_time + NUMERATOR + (off >>> OFFSET_LPF_GAIN); sync_offset <= off.
  - If both flags are set, override wins.
  - If neither flag is set: no change, no pulse.
  - sync_valid = 1 for exactly the APPLY cycle, and only when a load or correct was performed.
- Incomplete master time: if rx_end arrives with fewer than 9 payload bytes received, go to IDLE without applying.
- Saturation: a difference above 2^(OFFSET_WIDTH-1)-1 or below -2^(OFFSET_WIDTH-1) clamps to that limit.
- Reset mid-packet: everything returns to reset values immediately (asynchronous). Bytes of the in-flight packet are ignored until the next rx_start.

Decomposition:
- Shared package jellyvl_etherneco_pkg:
  - packet-type constants (TIMSYNC = 8'h10)
  - flag bit indices (OVERRIDE = 0, CORRECT = 1)
  - payload offsets (FLAGS_POS = 0, TIME_POS = 1, SLOT_BASE = 9, SLOT_SIZE = 4)
  - the responder state enum
- Sub-module jellyvl_etherneco_synctimer_timer: the free-running timer with load/adjust inputs and the saturating offset and LPF arithmetic. The master-side timer reuses it.

Test Plan:
- Override load: 8-byte master time 0x0000_0000_0001_0000, flags=0x01, node_id=1, 20-byte payload, 1 byte/cycle. Required: sync_valid pulses once; right after APPLY, current_time = 0x10000 + 16 + cycles(rx_start→APPLY)*8 + 8; pos 9..12 replaced with rx_time[31:0] LSB first; all other positions show replace_valid=0.
- Correct with LPF: local timer ahead of target by 160. Required: flags=0x02 gives sync_offset=-160 and a timer step of 8-10 = -2 in the APPLY cycle. A second run with an offset of +2^30 gives sync_offset=+8388607 (saturated).
- Error abort: rx_error mid-payload. Required: no sync_valid, timer keeps +8 per cycle, FSM returns to IDLE; the next good packet applies normally.
- Foreign type and node 0: rx_type=0x20 produces no replacement and no pulse. node_id=0 with type 0x10 applies the timing but never asserts replace_valid.
- Short packet / slot out of range: 6-byte payload with rx_end produces no apply. node_id=5 with a 20-byte payload produces no replacement.
- Async reset: drop reset for 1 ns mid-payload while clk is stopped. Required: outputs go to 0 immediately; after release, the timer counts 0, 8, 16…
